seq_divider: RTL
================

Name: seq_divider

Overview:
- Iterative multi-cycle divide/remainder unit for the RV32 M-extension ops DIV, DIVU, REM and REMU.
- It sits beside the ALU; the ALU's adder/subtractor chain runs in the forward direction, and this block is the inverse (restoring division by repeated subtraction).
- The pipeline control stalls on busy and takes result when done pulses.
- It uses one subtract-and-shift step per clock.

Parameters:
- WIDTH, 32, operand and result width in bits (must be ≥ 2).

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only while the block is accepting (IDLE or DONE).
- op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  WIDTH  rs1 value, sampled with start.
- divisor  input  WIDTH  rs2 value, sampled with start.
- busy  output  1  high while in CALC or FIXUP.
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); held until the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, result=0, and all internal registers are cleared.
- Reset asserted mid-operation aborts immediately; no done is produced.
- States:
  - IDLE, CALC, FIXUP and DONE.
  - start is accepted in IDLE or DONE. It is ignored in CALC and FIXUP, and any operands presented then are discarded.
- Accept edge:
  - Latch op.
  - Signed ops (DIV/REM): take |dividend| and |divisor|. Record q_neg = sign(dividend) XOR sign(divisor), and r_neg = sign(dividend).
  - Unsigned ops: use the operands as-is, with q_neg = r_neg = 0.
  - Clear the remainder register and set count = WIDTH.
- Special cases, decided at the accept edge with no CALC:
  - divisor == 0: quotient = all ones and remainder = dividend (unmodified). Go directly to DONE.
  - Signed overflow (DIV/REM, dividend = 1 followed by WIDTH−1 zeros, divisor = all ones): quotient = dividend and remainder = 0. Go directly to DONE.
  - Both cases give done one cycle after the accept edge.
- CALC, once per cycle for WIDTH cycles:
  - Shift {rem, quo} left by 1, with the dividend MSB entering rem.
  - Compute trial = rem − |divisor| at WIDTH+1 bits.
  - If trial is non-negative: rem = trial[WIDTH−1:0] and the quotient LSB = 1. Otherwise the quotient LSB = 0.
  - Decrement count; when count reaches 1 on an edge, go to FIXUP.
- FIXUP, one cycle:
  - Negate the quotient (two's complement) if q_neg.
  - Negate the remainder if r_neg.
  - Select result by op. Go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - The next state is IDLE, or the accept path if start=1 in this cycle (back-to-back issue is allowed).
- Latency: normal ops assert done WIDTH+2 cycles after the accept edge, which is 34 cycles for WIDTH=32.
- result updates only on entry to DONE. It is stable in IDLE and during subsequent CALC/FIXUP until the next DONE.
- All arithmetic is two's complement modulo 2^WIDTH. No internal width beyond WIDTH+1 bits is needed.

Decomposition:
- Shared package (div_pkg) holds:
  - op encodings: DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11.
  - state encodings for IDLE, CALC, FIXUP and DONE.
- One natural sub-module is div_step: a combinational single restoring step (shifted rem and divisor in; new rem and quotient bit out), built on the team's subtractor.
- The top level holds the FSM, counter, sign handling and special-case detection.

Test Plan:
- DIVU 100 / 7 → result 14, done exactly 34 cycles after the accept edge; REMU with the same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3); REM −7 / 2 → 0xFFFFFFFF (−1); REM 7 / −2 → 1.
- Divide by zero: DIVU 0x1234 / 0 → 0xFFFFFFFF; REM 0x1234 / 0 → 0x1234; done one cycle after the accept edge.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0; done one cycle after the accept edge.
- Pulse start with operands 9/3 at cycle 5 of a 100/7 DIVU → ignored, result 14. Then start in the DONE cycle with DIVU 9/3 → accepted, next done gives 3.
- Assert rst_n low at cycle 10 of CALC → busy=0, done=0, result=0 immediately (asynchronously). After release, a fresh DIVU 50/5 → 10 with nominal latency.

Source files
------------

// File: rtl/div_pkg.sv
// Shared encodings for the iterative divide/remainder unit.
package div_pkg;

  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CALC  = 2'b01,
    S_FIXUP = 2'b10,
    S_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Issue/result bundle between pipeline control (master) and the divider (slave).
interface seq_divider_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, dividend, divisor, input busy, done, result);
  modport slave  (input start, op, dividend, divisor, output busy, done, result);

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract of the shifted remainder.
// No state; the caller registers the outputs once per clock.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_sh,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // rem_sh < 2*dvs, so the difference always fits and bit WIDTH is a true sign bit.
  assign trial   = rem_sh - {1'b0, dvs};
  assign q_bit   = ~trial[WIDTH];
  assign rem_nxt = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// RV32M DIV/DIVU/REM/REMU, one restoring step per clock; done WIDTH+2 cycles after accept
// (1 for divide-by-zero/overflow). New requests are accepted only in IDLE or DONE.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] rem, quo, dvs, result_q;
  logic [CW-1:0]    count;

  logic             accept, is_signed, want_rem, div0, ovf, q_bit, busy, done;
  logic [WIDTH-1:0] abs_a, abs_b, rem_nxt, quo_f, rem_f;

  assign accept    = bus.start && (state == S_IDLE || state == S_DONE);
  assign is_signed = (bus.op == DIV_OP) || (bus.op == REM_OP);
  assign want_rem  = (bus.op == REM_OP) || (bus.op == REMU_OP);
  assign div0      = (bus.divisor == '0);
  assign ovf       = is_signed && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
  assign abs_a     = (is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign abs_b     = (is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_sh  ({rem, quo[WIDTH-1]}),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  assign quo_f = q_neg ? -quo : quo;
  assign rem_f = r_neg ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (!bus.start)         state_nxt = S_IDLE;
        else if (div0 || ovf)   state_nxt = S_DONE;
        else                    state_nxt = S_CALC;
      end
      S_CALC:  if (count == CW'(1)) state_nxt = S_FIXUP;
      S_FIXUP: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_CALC, S_FIXUP: busy = 1'b1;
      S_DONE:          done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      count    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      q_neg <= is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
      r_neg <= is_signed && bus.dividend[WIDTH-1];
      quo   <= abs_a;
      dvs   <= abs_b;
      rem   <= '0;
      count <= CW'(WIDTH);
      // Special cases skip CALC, so the result is committed right at the accept edge.
      if (div0)     result_q <= want_rem ? bus.dividend : '1;
      else if (ovf) result_q <= want_rem ? '0 : bus.dividend;
    end else if (state == S_CALC) begin
      rem   <= rem_nxt;
      quo   <= {quo[WIDTH-2:0], q_bit};
      count <= count - CW'(1);
    end else if (state == S_FIXUP) begin
      result_q <= (op_q == REM_OP || op_q == REMU_OP) ? rem_f : quo_f;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;

endmodule
